// File: rtl/sound_seq_if.sv
// Control, ROM and channel-output bundle for the sound command sequencer.
// The slave modport is the sequencer side; master is the controller/ROM/oscillator side.
interface sound_seq_if #(
  parameter int NUM_CH = 4
);
  logic                start;
  logic                stop;
  logic [12:0]         rom_addr;
  logic [15:0]         rom_data;
  logic [8*NUM_CH-1:0] note;
  logic [8*NUM_CH-1:0] vol;
  logic [8*NUM_CH-1:0] wave;
  logic [NUM_CH-1:0]   key_on;
  logic                busy;
  logic                done;
  logic                err;

  modport slave (
    input  start, stop, rom_data,
    output rom_addr, note, vol, wave, key_on, busy, done, err
  );

  modport master (
    output start, stop, rom_data,
    input  rom_addr, note, vol, wave, key_on, busy, done, err
  );
endinterface

// File: rtl/sound_seq.sv
// Sound command-stream reader: fetches ROM words, decodes them, drives per-channel note/vol/wave/key_on.
// Optional SOUND_SEQ_LOOP_EN: the END opcode restarts the stream at START_ADDR instead of stopping.
module sound_seq #(
  parameter int          NUM_CH     = 4,
  parameter logic [12:0] START_ADDR = 13'h0,
  parameter int          CLK_DIV    = 256
) (
  input  logic       clk,
  input  logic       asyncrst_n,
  sound_seq_if.slave bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_WAIT    = 4'd2,
    S_DECODE  = 4'd3,
    S_OPFETCH = 4'd4,
    S_OPWAIT  = 4'd5,
    S_EXEC    = 4'd6,
    S_PLAY    = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [12:0]         r_rom_addr;
  logic [15:0]         r_cmd;
  logic [15:0]         r_opnd;
  logic [11:0]         r_tempo_pre;
  logic [15:0]         r_tempo_mul;
  logic [DIV_W-1:0]    r_cnt_div;
  logic [11:0]         r_cnt_pre;
  logic [15:0]         r_cnt_mul;
  logic [15:0]         r_cnt_dur;
  logic [8*NUM_CH-1:0] r_note;
  logic [8*NUM_CH-1:0] r_vol;
  logic [8*NUM_CH-1:0] r_wave;
  logic [NUM_CH-1:0]   r_key_on;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic [3:0] w_dec_op;
  logic [3:0] w_exec_op;
  logic       w_is_end;
  logic       w_div_last;
  logic       w_pre_last;
  logic       w_mul_last;
  logic       w_dur_last;
  logic       w_expire;
  logic       w_busy;
  logic       w_done;
  logic       w_start_ok;

  assign w_dec_op   = bus.rom_data[15:12];
  assign w_exec_op  = r_cmd[15:12];
  // 16'hffff carries the END opcode but is reserved as an illegal word.
  assign w_is_end   = (w_exec_op == 4'hf) && (r_cmd != 16'hffff);
  assign w_div_last = (r_cnt_div == DIV_LAST);
  assign w_pre_last = (r_cnt_pre == r_tempo_pre);
  assign w_mul_last = (r_cnt_mul == (r_tempo_mul - 16'd1));
  assign w_dur_last = (r_cnt_dur == (r_opnd - 16'd1));
  assign w_expire   = w_div_last & w_pre_last & w_mul_last & w_dur_last;

  // State register.
  always_ff @(posedge clk or negedge asyncrst_n) begin
    if (!asyncrst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; stop overrides every other transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) w_next = S_FETCH;
        else           w_next = r_state;
      end
      S_FETCH:   w_next = S_WAIT;
      S_WAIT:    w_next = S_DECODE;
      S_DECODE: begin
        if ((w_dec_op == 4'h1) || (w_dec_op == 4'h4)) w_next = S_OPFETCH;
        else                                          w_next = S_EXEC;
      end
      S_OPFETCH: w_next = S_OPWAIT;
      S_OPWAIT:  w_next = S_EXEC;
      S_EXEC: begin
        case (w_exec_op)
          4'h1, 4'h2, 4'h3: w_next = S_FETCH;
          4'h4: begin
            if (r_opnd != 16'd0) w_next = S_PLAY;
            else                 w_next = S_FETCH;
          end
          default: begin
`ifdef SOUND_SEQ_LOOP_EN
            if (w_is_end) w_next = S_FETCH;
            else          w_next = S_DONE;
`else
            w_next = S_DONE;
`endif
          end
        endcase
      end
      S_PLAY: begin
        if (w_expire) w_next = S_FETCH;
        else          w_next = S_PLAY;
      end
      default:   w_next = S_IDLE;
    endcase
    if (bus.stop) w_next = S_IDLE;
    else          w_next = w_next;
  end

  // Status decode from the upcoming state so busy/done are registered alongside it.
  always_comb begin
    w_busy     = (w_next != S_IDLE) && (w_next != S_DONE);
    w_done     = (w_next == S_DONE);
    w_start_ok = bus.start && !bus.stop && ((r_state == S_IDLE) || (r_state == S_DONE));
  end

  // Datapath: address, command capture, channel registers and the duration counters.
  always_ff @(posedge clk or negedge asyncrst_n) begin
    if (!asyncrst_n) begin
      r_rom_addr  <= 13'h0;
      r_cmd       <= 16'h0;
      r_opnd      <= 16'h0;
      r_tempo_pre <= 12'h0;
      r_tempo_mul <= 16'd1;
      r_cnt_div   <= '0;
      r_cnt_pre   <= 12'h0;
      r_cnt_mul   <= 16'h0;
      r_cnt_dur   <= 16'h0;
      r_note      <= '0;
      r_vol       <= '0;
      r_wave      <= '0;
      r_key_on    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_busy <= w_busy;
      r_done <= w_done;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_rom_addr <= START_ADDR;
            r_err      <= 1'b0;
          end
        end
        S_DECODE: begin
          r_cmd      <= bus.rom_data;
          r_rom_addr <= r_rom_addr + 13'd1;
        end
        S_OPWAIT: begin
          r_opnd     <= bus.rom_data;
          r_rom_addr <= r_rom_addr + 13'd1;
        end
        S_EXEC: begin
          case (w_exec_op)
            4'h1: begin
              r_tempo_pre <= r_cmd[11:0];
              r_tempo_mul <= (r_opnd == 16'd0) ? 16'd1 : r_opnd;
            end
            4'h2: begin
              for (int i = 0; i < NUM_CH; i++) begin
                if (r_cmd[9:8] == 2'(i)) r_vol[8*i +: 8] <= r_cmd[7:0];
              end
            end
            4'h3: begin
              for (int i = 0; i < NUM_CH; i++) begin
                if (r_cmd[9:8] == 2'(i)) r_wave[8*i +: 8] <= r_cmd[7:0];
              end
            end
            4'h4: begin
              for (int i = 0; i < NUM_CH; i++) begin
                if (r_cmd[9:8] == 2'(i)) begin
                  r_note[8*i +: 8] <= r_cmd[7:0];
                  if (r_opnd != 16'd0) r_key_on[i] <= 1'b1;
                end
              end
              r_cnt_div <= '0;
              r_cnt_pre <= 12'h0;
              r_cnt_mul <= 16'h0;
              r_cnt_dur <= 16'h0;
            end
            default: begin
              r_key_on <= '0;
              if (w_is_end) begin
`ifdef SOUND_SEQ_LOOP_EN
                r_rom_addr <= START_ADDR;
`endif
              end else begin
                r_err <= 1'b1;
              end
            end
          endcase
        end
        S_PLAY: begin
          // Nested counters: clocks -> prescaler steps -> ticks -> tempo_mul groups -> duration.
          if (w_div_last) begin
            r_cnt_div <= '0;
            if (w_pre_last) begin
              r_cnt_pre <= 12'h0;
              if (w_mul_last) begin
                r_cnt_mul <= 16'h0;
                r_cnt_dur <= r_cnt_dur + 16'd1;
              end else begin
                r_cnt_mul <= r_cnt_mul + 16'd1;
              end
            end else begin
              r_cnt_pre <= r_cnt_pre + 12'd1;
            end
          end else begin
            r_cnt_div <= r_cnt_div + DIV_W'(1);
          end
          if (w_expire) r_key_on <= '0;
        end
        default: begin
        end
      endcase
      if (bus.stop) r_key_on <= '0;
    end
  end

  assign bus.rom_addr = r_rom_addr;
  assign bus.note     = r_note;
  assign bus.vol      = r_vol;
  assign bus.wave     = r_wave;
  assign bus.key_on   = r_key_on;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_sound_seq.sv
// Randomised bench for sound_seq: an instruction-level timing model predicts every output each cycle,
// with literal checks on the documented scenarios (tempo/note duration, op-0 note, illegal word, stop, reset).
module tb_sound_seq;
  localparam int NUM_CH  = 4;
  localparam int CLK_DIV = 4;
`ifdef SOUND_SEQ_LOOP_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sound_seq_if #(.NUM_CH(NUM_CH)) bus ();

  sound_seq #(.NUM_CH(NUM_CH), .START_ADDR(13'h0), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .asyncrst_n(rst_n), .bus(bus)
  );

  logic [15:0] rom [0:63];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr[5:0]];

  int total = 0;
  int bad = 0;
  int key_cnt = 0;
  always @(negedge clk) if (bus.key_on[0]) key_cnt <= key_cnt + 1;

  logic [7:0]        e_note [NUM_CH];
  logic [7:0]        e_vol  [NUM_CH];
  logic [7:0]        e_wave [NUM_CH];
  logic [NUM_CH-1:0] e_key;
  logic              e_busy, e_done, e_err;
  int                m_pre, m_mul;
  bit                chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [8*NUM_CH-1:0] xn, xv, xw;
    if (chk_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        xn[8*i +: 8] = e_note[i];
        xv[8*i +: 8] = e_vol[i];
        xw[8*i +: 8] = e_wave[i];
      end
      check("note", 32'(bus.note), 32'(xn));
      check("vol", 32'(bus.vol), 32'(xv));
      check("wave", 32'(bus.wave), 32'(xw));
      check("key_on", 32'(bus.key_on), 32'(e_key));
      check("busy", 32'(bus.busy), 32'(e_busy));
      check("done", 32'(bus.done), 32'(e_done));
      check("err", 32'(bus.err), 32'(e_err));
    end
  end

  // Instruction-level model: 4 clocks per 1-word command, 6 per 2-word command, plus the note length.
  task automatic run_model(input int passes, output bit ended, output int words);
    int pc, op, ch, n, left;
    logic [15:0] w, opnd;
    e_busy = 1'b1; e_done = 1'b0; e_err = 1'b0;
    pc = 0; ended = 1'b0; left = passes; words = 0;
    forever begin
      w = rom[pc]; pc++;
      op = int'(w[15:12]); ch = int'(w[9:8]); opnd = 16'h0;
      if (op == 1 || op == 4) begin
        opnd = rom[pc]; pc++;
        repeat (6) @(posedge clk);
      end else begin
        repeat (4) @(posedge clk);
      end
      if (op == 1) begin
        m_pre = int'(w[11:0]);
        m_mul = (opnd == 16'h0) ? 1 : int'(opnd);
      end else if (op == 2) begin
        e_vol[ch] = w[7:0];
      end else if (op == 3) begin
        e_wave[ch] = w[7:0];
      end else if (op == 4) begin
        e_note[ch] = w[7:0];
        if (opnd != 16'h0) begin
          n = int'(opnd) * m_mul * (m_pre + 1) * CLK_DIV;
          e_key[ch] = 1'b1;
          repeat (n) @(posedge clk);
          e_key[ch] = 1'b0;
        end
      end else if (op == 15 && w != 16'hffff) begin
`ifdef SOUND_SEQ_LOOP_EN
        if (left > 1) begin
          left--;
          pc = 0;
          continue;
        end
        words = pc;
        return;
`else
        e_busy = 1'b0; e_done = 1'b1; ended = 1'b1; words = pc;
        return;
`endif
      end else begin
        e_err = 1'b1; e_busy = 1'b0; e_done = 1'b1; ended = 1'b1; words = pc;
        return;
      end
    end
  endtask

  task automatic load(input logic [15:0] p [$]);
    for (int i = 0; i < 64; i++) rom[i] = 16'h0;
    foreach (p[i]) rom[i] = p[i];
  endtask

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
  endtask

  task automatic go(output bit ended, output int words);
    pulse_start();
    run_model(PASSES, ended, words);
  endtask

  task automatic finish_run(input bit ended, input int words);
    if (ended) begin
      @(negedge clk); #1;
      check("end_addr", 32'(bus.rom_addr), 32'(words));
    end else begin
      @(negedge clk); bus.stop = 1'b1;
      @(posedge clk); #1; bus.stop = 1'b0;
      e_busy = 1'b0; e_key = '0;
      @(negedge clk); #1;
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < NUM_CH; i++) begin
      e_note[i] = 8'h0; e_vol[i] = 8'h0; e_wave[i] = 8'h0;
    end
    e_key = '0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
    m_pre = 0; m_mul = 1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, 32'(bus.rom_addr), 32'h0);
    check({tag, "_note"}, 32'(bus.note), 32'h0);
    check({tag, "_vol"}, 32'(bus.vol), 32'h0);
    check({tag, "_wave"}, 32'(bus.wave), 32'h0);
    check({tag, "_key"}, 32'(bus.key_on), 32'h0);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check({tag, "_done"}, 32'(bus.done), 32'h0);
    check({tag, "_err"}, 32'(bus.err), 32'h0);
  endtask

  task automatic wait_key0(input string nm);
    for (int k = 0; k < 200 && !bus.key_on[0]; k++) @(negedge clk);
    check(nm, 32'(bus.key_on[0]), 32'h1);
  endtask

  logic [15:0] spec_prog [$] = '{16'h1032, 16'h0002, 16'h2001, 16'h4020, 16'h0004, 16'hf000};

  initial begin
    bit ended;
    int words, k0;
    logic [15:0] q [$];
    bus.start = 1'b0; bus.stop = 1'b0;
    reset_model();
    load(spec_prog);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Documented tempo/volume/note scenario.
    k0 = key_cnt;
    go(ended, words);
    finish_run(ended, words);
    check("spec_key_clks", 32'(key_cnt - k0), 32'(1632 * PASSES));
    check("spec_vol0", 32'(bus.vol[7:0]), 32'h01);
    check("spec_note0", 32'(bus.note[7:0]), 32'h20);
    check("spec_done", 32'(bus.done), (PASSES == 1) ? 32'h1 : 32'h0);

    // Zero-length note never keys on.
    load('{16'h4105, 16'h0000, 16'h2203, 16'hf000});
    k0 = key_cnt;
    go(ended, words);
    finish_run(ended, words);
    check("op0_key", 32'(key_cnt - k0), 32'h0);
    check("op0_note1", 32'(bus.note[15:8]), 32'h05);
    check("op0_vol2", 32'(bus.vol[23:16]), 32'h03);

    // Illegal opcode.
    load('{16'h7123});
    go(ended, words);
    finish_run(ended, words);
    check("ill_err", 32'(bus.err), 32'h1);
    check("ill_done", 32'(bus.done), 32'h1);

    // Restart clears err; stop mid-PLAY.
    load(spec_prog);
    chk_en = 1'b0;
    pulse_start();
    @(negedge clk);
    check("restart_err", 32'(bus.err), 32'h0);
    check("restart_busy", 32'(bus.busy), 32'h1);
    wait_key0("stop_key_rise");
    repeat (100) @(negedge clk);
    bus.stop = 1'b1;
    @(posedge clk); #1; bus.stop = 1'b0;
    @(negedge clk);
    check("stop_key", 32'(bus.key_on), 32'h0);
    check("stop_busy", 32'(bus.busy), 32'h0);
    check("stop_done", 32'(bus.done), 32'h0);
    check("stop_note0", 32'(bus.note[7:0]), 32'h20);
    check("stop_vol0", 32'(bus.vol[7:0]), 32'h01);
    e_note[0] = 8'h20; e_vol[0] = 8'h01; e_key = '0;
    e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
    m_pre = 32'h32; m_mul = 2;
    chk_en = 1'b1;
    k0 = key_cnt;
    go(ended, words);
    finish_run(ended, words);
    check("restart_key_clks", 32'(key_cnt - k0), 32'(1632 * PASSES));

    // Random command streams.
    for (int r = 0; r < 25; r++) begin
      int n, kind, ch, op;
      q = {};
      n = $urandom_range(3, 8);
      for (int j = 0; j < n; j++) begin
        kind = $urandom_range(0, 3);
        ch = $urandom_range(0, 3);
        case (kind)
          0: begin
            q.push_back({4'h1, 12'($urandom_range(0, 3))});
            q.push_back(16'($urandom_range(0, 2)));
          end
          1: q.push_back({4'h2, 2'($urandom), 2'(ch), 8'($urandom)});
          2: q.push_back({4'h3, 2'($urandom), 2'(ch), 8'($urandom)});
          default: begin
            q.push_back({4'h4, 2'($urandom), 2'(ch), 8'($urandom)});
            q.push_back(16'($urandom_range(0, 3)));
          end
        endcase
      end
      kind = $urandom_range(0, 3);
      if (kind < 2) q.push_back({4'hf, 12'($urandom_range(0, 12'hffe))});
      else if (kind == 2) q.push_back(16'hffff);
      else begin
        op = $urandom_range(4, 14);
        if (op == 4) op = 0;
        q.push_back({4'(op), 12'($urandom)});
      end
      load(q);
      go(ended, words);
      finish_run(ended, words);
    end

    // Asynchronous reset mid-note, then recovery with default tempo.
    load(spec_prog);
    chk_en = 1'b0;
    pulse_start();
    wait_key0("arst_key_rise");
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("arst");
    reset_model();
    @(negedge clk); rst_n = 1'b1;
    chk_en = 1'b1;
    load('{16'h4013, 16'h0002, 16'hf000});
    k0 = key_cnt;
    go(ended, words);
    finish_run(ended, words);
    check("post_rst_key_clks", 32'(key_cnt - k0), 32'(8 * PASSES));

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
